// File: rtl/csr_file.sv
// Machine-mode CSR file: one combinational read port shared with the trap controller,
// a trap write port that overrides the instruction write port, and 64-bit cycle/instret counters.
module csr_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_active,
  input  logic [11:0] csr_trap_address,
  input  logic        csr_trap_write_enable,
  input  logic [31:0] csr_trap_write_data,
  input  logic [11:0] csr_read_address,
  input  logic [11:0] csr_write_address,
  input  logic        csr_write_enable,
  input  logic [31:0] csr_write_data,
  input  logic        instret_inc,
  output logic [31:0] csr_read_data,
  output logic        csr_illegal
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_reg;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [11:0] rd_addr;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;

  function automatic logic is_rw(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_ro(input logic [11:0] a);
    case (a)
      A_MISA, A_MIP, A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID,
      A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // The trap port wins outright; a simultaneous instruction write is discarded.
  always_comb begin
    wr_en   = csr_trap_write_enable | csr_write_enable;
    wr_addr = csr_write_address;
    wr_data = csr_write_data;
    if (csr_trap_write_enable) begin
      wr_addr = csr_trap_address;
      wr_data = csr_trap_write_data;
    end
  end

  assign cyc_lo_we = wr_en && (wr_addr == A_MCYCLE);
  assign cyc_hi_we = wr_en && (wr_addr == A_MCYCLEH);
  assign ins_lo_we = wr_en && (wr_addr == A_MINSTRET);
  assign ins_hi_we = wr_en && (wr_addr == A_MINSTRETH);

  assign rd_addr = trap_active ? csr_trap_address : csr_read_address;

  always_comb begin
    csr_read_data = 32'h0;
    case (rd_addr)
      A_MSTATUS:              csr_read_data = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      A_MISA:                 csr_read_data = MISA_VALUE;
      A_MIE:                  csr_read_data = mie_reg;
      A_MTVEC:                csr_read_data = mtvec;
      A_MSCRATCH:             csr_read_data = mscratch;
      A_MEPC:                 csr_read_data = mepc;
      A_MCAUSE:               csr_read_data = mcause;
      A_MTVAL:                csr_read_data = mtval;
      A_MCYCLE,   A_CYCLE:    csr_read_data = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:   csr_read_data = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  csr_read_data = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: csr_read_data = minstret[63:32];
      default:                csr_read_data = 32'h0;
    endcase
  end

  assign csr_illegal = !(is_rw(rd_addr) || is_ro(rd_addr)) ||
                       (csr_write_enable && !is_rw(csr_write_address));

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_reg      <= 32'h0;
      mtvec        <= 32'h0;
      mscratch     <= 32'h0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mtval        <= 32'h0;
    end else if (wr_en) begin
      case (wr_addr)
        A_MSTATUS: begin
          mstatus_mie  <= wr_data[3];
          mstatus_mpie <= wr_data[7];
        end
        A_MIE:      mie_reg  <= wr_data;
        A_MTVEC:    mtvec    <= {wr_data[31:2], 2'b00};
        A_MSCRATCH: mscratch <= wr_data;
        A_MEPC:     mepc     <= {wr_data[31:2], 2'b00};
        A_MCAUSE:   mcause   <= wr_data;
        A_MTVAL:    mtval    <= wr_data;
        default: ;
      endcase
    end
  end

  // A write to either half freezes the whole counter for that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (cyc_lo_we || cyc_hi_we) begin
        if (cyc_lo_we) mcycle[31:0]  <= wr_data;
        if (cyc_hi_we) mcycle[63:32] <= wr_data;
      end else begin
        mcycle <= mcycle + 64'd1;
      end
      if (ins_lo_we || ins_hi_we) begin
        if (ins_lo_we) minstret[31:0]  <= wr_data;
        if (ins_hi_we) minstret[63:32] <= wr_data;
      end else if (instret_inc) begin
        minstret <= minstret + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a vector table for register behaviour plus
// hand-written sequences for reset, counter carry/wrap and reset priority.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_active;
  logic [11:0] csr_trap_address;
  logic        csr_trap_write_enable;
  logic [31:0] csr_trap_write_data;
  logic [11:0] csr_read_address;
  logic [11:0] csr_write_address;
  logic        csr_write_enable;
  logic [31:0] csr_write_data;
  logic        instret_inc;
  logic [31:0] csr_read_data;
  logic        csr_illegal;

  int checks = 0;
  int failures = 0;

  csr_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .trap_active           (trap_active),
    .csr_trap_address      (csr_trap_address),
    .csr_trap_write_enable (csr_trap_write_enable),
    .csr_trap_write_data   (csr_trap_write_data),
    .csr_read_address      (csr_read_address),
    .csr_write_address     (csr_write_address),
    .csr_write_enable      (csr_write_enable),
    .csr_write_data        (csr_write_data),
    .instret_inc           (instret_inc),
    .csr_read_data         (csr_read_data),
    .csr_illegal           (csr_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ta;
    logic [11:0] taddr;
    logic        twe;
    logic [31:0] twd;
    logic [11:0] raddr;
    logic [11:0] waddr;
    logic        we;
    logic [31:0] wd;
    logic        inc;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    trap_active = 1'b0; csr_trap_address = 12'h0; csr_trap_write_enable = 1'b0;
    csr_trap_write_data = 32'h0; csr_read_address = 12'h300; csr_write_address = 12'h0;
    csr_write_enable = 1'b0; csr_write_data = 32'h0; instret_inc = 1'b0;
  endtask

  task automatic iwrite(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    csr_write_address = a; csr_write_enable = 1'b1; csr_write_data = d;
    @(posedge clk);
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_read_address = a;
    #1;
    check(nm, csr_read_data, exp);
  endtask

  task automatic v(input logic ta, input logic [11:0] taddr, input logic twe, input logic [31:0] twd,
                   input logic [11:0] raddr, input logic [11:0] waddr, input logic we,
                   input logic [31:0] wd, input logic inc, input logic [31:0] exp_rd, input logic exp_ill);
    vec_t r;
    r.ta = ta; r.taddr = taddr; r.twe = twe; r.twd = twd; r.raddr = raddr; r.waddr = waddr;
    r.we = we; r.wd = wd; r.inc = inc; r.exp_rd = exp_rd; r.exp_ill = exp_ill;
    vecs.push_back(r);
  endtask

  initial begin
    // expected read data is the pre-edge value for that vector's inputs
    v(0, 12'h000, 0, 32'h0,           12'h305, 12'h305, 1, 32'h1000_AA03, 0, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'h305, 12'h000, 0, 32'h0,         0, 32'h1000_AA00,   0);
    v(0, 12'h000, 0, 32'h0,           12'h300, 12'h300, 1, 32'hFFFF_FFFF, 0, 32'h0000_1800,   0);
    v(0, 12'h000, 0, 32'h0,           12'h300, 12'h000, 0, 32'h0,         0, 32'h0000_1888,   0);
    v(0, 12'h000, 0, 32'h0,           12'h301, 12'h341, 1, 32'h0000_1111, 0, 32'h4000_0100,   0);
    v(0, 12'h000, 0, 32'h0,           12'h341, 12'h342, 1, 32'd11,        0, 32'h0000_1110,   0);
    v(1, 12'h305, 0, 32'h0,           12'h7C0, 12'h000, 0, 32'h0,         0, 32'h1000_AA00,   0);
    v(0, 12'h000, 0, 32'h0,           12'h342, 12'h000, 0, 32'h0,         0, 32'h0000_000B,   0);
    v(0, 12'h000, 0, 32'h0,           12'h340, 12'h340, 1, 32'h1234_5678, 0, 32'h0,           0);
    v(0, 12'h341, 1, 32'h0000_2000,   12'h340, 12'h340, 1, 32'hDEAD_BEEF, 0, 32'h1234_5678,   0);
    v(0, 12'h000, 0, 32'h0,           12'h341, 12'h000, 0, 32'h0,         0, 32'h0000_2000,   0);
    v(0, 12'h000, 0, 32'h0,           12'h340, 12'h000, 0, 32'h0,         0, 32'h1234_5678,   0);
    v(0, 12'h000, 0, 32'h0,           12'h300, 12'hC00, 1, 32'h0000_0055, 0, 32'h0000_1888,   1);
    v(0, 12'h000, 0, 32'h0,           12'hF14, 12'hF14, 1, 32'h0000_0001, 0, 32'h0,           1);
    v(0, 12'h000, 0, 32'h0,           12'hF14, 12'h000, 0, 32'h0,         0, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'h7C0, 12'h000, 0, 32'h0,         0, 32'h0,           1);
    v(0, 12'h301, 1, 32'h0,           12'h301, 12'h000, 0, 32'h0,         0, 32'h4000_0100,   0);
    v(0, 12'h000, 0, 32'h0,           12'h301, 12'h000, 0, 32'h0,         0, 32'h4000_0100,   0);
    v(0, 12'h342, 1, 32'hFFFF_FFFF,   12'h304, 12'h000, 0, 32'h0,         0, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'h342, 12'h304, 1, 32'hA5A5_A5A5, 0, 32'hFFFF_FFFF,   0);
    v(0, 12'h000, 0, 32'h0,           12'h304, 12'h343, 1, 32'h0BAD_F00D, 0, 32'hA5A5_A5A5,   0);
    v(0, 12'h000, 0, 32'h0,           12'h343, 12'h000, 0, 32'h0,         0, 32'h0BAD_F00D,   0);
    v(0, 12'h000, 0, 32'h0,           12'h344, 12'h000, 0, 32'h0,         0, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'h300, 12'h300, 1, 32'h0,         0, 32'h0000_1888,   0);
    v(0, 12'h000, 0, 32'h0,           12'h300, 12'h7C0, 1, 32'h0,         0, 32'h0000_1800,   1);
    v(0, 12'h000, 0, 32'h0,           12'hB02, 12'h000, 0, 32'h0,         0, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'hC02, 12'h000, 0, 32'h0,         1, 32'h0,           0);
    v(0, 12'h000, 0, 32'h0,           12'hB02, 12'h000, 0, 32'h0,         0, 32'h0000_0001,   0);
    v(0, 12'h000, 0, 32'h0,           12'hC82, 12'h000, 0, 32'h0,         0, 32'h0,           0);

    // reset
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd("reset_mstatus", 12'h300, 32'h0000_1800);
    rd("reset_mcycle", 12'hB00, 32'h0);
    rd("reset_mtvec", 12'h305, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    csr_read_address = 12'hB00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd("mcycle_after5", 12'hB00, 32'd5);
    rd("cycle_mirror5", 12'hC00, 32'd5);
    rd("mcycleh_after5", 12'hB80, 32'h0);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mstatus_reset", 12'h300, 32'h0000_1800);

    // register table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      trap_active = vecs[i].ta; csr_trap_address = vecs[i].taddr;
      csr_trap_write_enable = vecs[i].twe; csr_trap_write_data = vecs[i].twd;
      csr_read_address = vecs[i].raddr; csr_write_address = vecs[i].waddr;
      csr_write_enable = vecs[i].we; csr_write_data = vecs[i].wd; instret_inc = vecs[i].inc;
      #1;
      check($sformatf("vec%0d_rd", i), csr_read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_ill", i), {31'b0, csr_illegal}, {31'b0, vecs[i].exp_ill});
      @(posedge clk);
    end

    // mcycle carry into the high word
    iwrite(12'hB00, 32'hFFFF_FFFF);
    iwrite(12'hB80, 32'h0);
    @(negedge clk);
    idle();
    rd("mcycle_lo_loaded", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_loaded", 12'hB80, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rd("mcycle_lo_carry", 12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("cycleh_mirror", 12'hC80, 32'h1);
    csr_write_address = 12'hC00; csr_write_enable = 1'b1; csr_write_data = 32'hFFFF_0000;
    #1;
    check("cycle_write_ill", {31'b0, csr_illegal}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    idle();
    rd("cycle_write_ignored", 12'hB00, 32'h1);

    // minstret wrap and write-suppresses-increment
    iwrite(12'hB82, 32'hFFFF_FFFF);
    iwrite(12'hB02, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    rd("minstret_loaded", 12'hB02, 32'hFFFF_FFFF);
    instret_inc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instret_inc = 1'b0;
    rd("minstret_wrap_lo", 12'hB02, 32'h0);
    rd("minstret_wrap_hi", 12'hB82, 32'h0);
    csr_write_address = 12'hB02; csr_write_enable = 1'b1; csr_write_data = 32'd7; instret_inc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    rd("minstret_write_wins", 12'hB02, 32'd7);
    rd("minstreth_untouched", 12'hB82, 32'h0);

    // reset beats simultaneous trap and instruction writes
    @(negedge clk);
    rst = 1'b1;
    csr_write_address = 12'h340; csr_write_enable = 1'b1; csr_write_data = 32'hFFFF_FFFF;
    csr_trap_address = 12'h341; csr_trap_write_enable = 1'b1; csr_trap_write_data = 32'h44;
    trap_active = 1'b1; instret_inc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trap_active = 1'b0;
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    rd("rst_mie", 12'h304, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mcycle", 12'hB00, 32'h0);
    rd("rst_minstret", 12'hB02, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rd("rst_hold_mcycle", 12'hB00, 32'h0);
    rd("rst_hold_mepc", 12'h341, 32'h0);
    idle();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
